// File: rtl/cla_4.sv
// cla_4 : registered 4-bit carry-lookahead adder.
//
// Adds two 4-bit operands and a carry-in using flat two-level lookahead
// carries (no ripple chain), then registers the sum, carry-out and signed
// overflow flag. A new operand set is accepted on every rising clock edge
// and its result appears on the outputs one edge later.
//
// Ports:
//   clk  in   1  rising-edge clock for all state
//   rst  in   1  synchronous active-high reset, has priority over capture
//   A    in   4  addend A (unsigned or two's complement)
//   B    in   4  addend B (unsigned or two's complement)
//   C0   in   1  carry-in
//   S    out  4  registered sum bits
//   C4   out  1  registered carry-out
//   V    out  1  registered signed overflow flag (C4 ^ C3)
//   PG   out  1  registered group propagate  (only with CLA_4_GROUP_PG_EN)
//   GG   out  1  registered group generate   (only with CLA_4_GROUP_PG_EN)
//
// Build option:
//   CLA_4_GROUP_PG_EN  when defined, adds the PG/GG ports and their logic for
//                      cascading into a second-level lookahead unit. When
//                      undefined, those ports and their logic are absent.

module cla_4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C0,
    output logic [3:0] S,
    output logic       C4,
    output logic       V
`ifdef CLA_4_GROUP_PG_EN
    ,
    output logic       PG,
    output logic       GG
`endif
);

    // Per-bit generate and propagate.
    logic [3:0] g;
    logic [3:0] p;

    // Lookahead carries; c[0] is the carry-in, c[4] the carry-out.
    logic [4:0] c;

    // Next-state values for the output registers.
    logic [3:0] s_d;
    logic       c4_d;
    logic       v_d;

    always_comb begin
        g = A & B;
        p = A ^ B;
    end

    // Every carry is a single sum-of-products of g, p and C0 so that no
    // carry depends on another computed carry.
    always_comb begin
        c[0] = C0;

        c[1] = g[0]
             | (p[0] & C0);

        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & C0);

        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & C0);

        c[4] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & C0);
    end

    always_comb begin
        s_d  = p ^ c[3:0];
        c4_d = c[4];
        // Signed overflow: carry into the sign bit differs from carry out.
        v_d  = c[4] ^ c[3];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            S  <= 4'b0000;
            C4 <= 1'b0;
            V  <= 1'b0;
        end else begin
            S  <= s_d;
            C4 <= c4_d;
            V  <= v_d;
        end
    end

`ifdef CLA_4_GROUP_PG_EN
    // Group terms ignore C0 so a second-level unit can form its own carries.
    logic pg_d;
    logic gg_d;

    always_comb begin
        pg_d = p[3] & p[2] & p[1] & p[0];
        gg_d = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            PG <= 1'b0;
            GG <= 1'b0;
        end else begin
            PG <= pg_d;
            GG <= gg_d;
        end
    end
`endif

endmodule

// File: tb/tb_cla_4.sv
// Self-checking bench for cla_4. Expected results come from plain integer
// arithmetic on the operands (unsigned sum, signed sum range check), not from
// a gate-level restatement of the adder.

module tb_cla_4;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       C0;
    logic [3:0] S;
    logic       C4;
    logic       V;
`ifdef CLA_4_GROUP_PG_EN
    logic       PG;
    logic       GG;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    cla_4 dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .C0  (C0),
        .S   (S),
        .C4  (C4),
        .V   (V)
`ifdef CLA_4_GROUP_PG_EN
        ,
        .PG  (PG),
        .GG  (GG)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: returns {C4, V, S} for the given operands.
    function automatic logic [5:0] ref_sum(input logic [3:0] a, input logic [3:0] b,
                                           input logic c0);
        int usum;
        int sa;
        int sb;
        int ssum;
        logic [5:0] r;
        usum = int'(a) + int'(b) + int'(c0);
        sa   = a[3] ? int'(a) - 16 : int'(a);
        sb   = b[3] ? int'(b) - 16 : int'(b);
        ssum = sa + sb + int'(c0);
        r[3:0] = usum[3:0];
        r[5]   = (usum > 15);
        r[4]   = (ssum > 7) || (ssum < -8);
        return r;
    endfunction

    // Reference group terms: {PG, GG}.
    function automatic logic [1:0] ref_group(input logic [3:0] a, input logic [3:0] b);
        int s0;
        s0 = int'(a) + int'(b);
        return {((a ^ b) == 4'hF), (s0 > 15)};
    endfunction

    // Apply operands on the falling edge so they are stable at the next rise.
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c0,
                         input logic r);
        @(negedge clk);
        A   = a;
        B   = b;
        C0  = c0;
        rst = r;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        drive(4'h0, 4'h0, 1'b0, 1'b1);
        step();
        n_checks++;
        if ({C4, V, S} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_state: got C4=%b V=%b S=%b, want all 0", C4, V, S);
        end
`ifdef CLA_4_GROUP_PG_EN
        n_checks++;
        if ({PG, GG} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_group: got PG=%b GG=%b, want 0 0", PG, GG);
        end
`endif
        // First edge after release reflects operands sampled there.
        drive(4'h3, 4'h4, 1'b1, 1'b0);
        step();
        n_checks++;
        if ({C4, V, S} !== ref_sum(4'h3, 4'h4, 1'b1)) begin
            n_fail++;
            $display("FAIL reset_release: got %b, want %b", {C4, V, S},
                     ref_sum(4'h3, 4'h4, 1'b1));
        end
    endtask

    task automatic test_directed;
        logic [12:0] vec [5];
        vec[0] = {4'b1010, 4'b0101, 1'b1, 4'b0000};
        vec[1] = {4'b0101, 4'b1010, 1'b0, 4'b0000};
        vec[2] = {4'b1111, 4'b0000, 1'b1, 4'b0000};
        vec[3] = {4'b0000, 4'b1111, 1'b0, 4'b0000};
        vec[4] = {4'b0111, 4'b0001, 1'b0, 4'b0000};
        for (int i = 0; i < 5; i++) begin
            logic [5:0] exp;
            exp = ref_sum(vec[i][12:9], vec[i][8:5], vec[i][4]);
            drive(vec[i][12:9], vec[i][8:5], vec[i][4], 1'b0);
            step();
            n_checks++;
            if ({C4, V, S} !== exp) begin
                n_fail++;
                $display("FAIL directed_%0d: got C4=%b V=%b S=%b, want C4=%b V=%b S=%b",
                         i, C4, V, S, exp[5], exp[4], exp[3:0]);
            end
`ifdef CLA_4_GROUP_PG_EN
            n_checks++;
            if ({PG, GG} !== ref_group(vec[i][12:9], vec[i][8:5])) begin
                n_fail++;
                $display("FAIL directed_group_%0d: got %b, want %b", i, {PG, GG},
                         ref_group(vec[i][12:9], vec[i][8:5]));
            end
`endif
        end
        // Fixed spot values independent of the model.
        drive(4'b1111, 4'b0000, 1'b1, 1'b0);
        step();
        n_checks++;
        if ({C4, S} !== 5'b10000) begin
            n_fail++;
            $display("FAIL wrap_around: got C4=%b S=%b, want C4=1 S=0000", C4, S);
        end
        drive(4'b0111, 4'b0001, 1'b0, 1'b0);
        step();
        n_checks++;
        if ({C4, V, S} !== 6'b011000) begin
            n_fail++;
            $display("FAIL overflow: got C4=%b V=%b S=%b, want C4=0 V=1 S=1000", C4, V, S);
        end
    endtask

    task automatic test_reset_priority;
        // Reset on the same edge as an overflowing operand set.
        drive(4'b0111, 4'b0001, 1'b0, 1'b1);
        step();
        n_checks++;
        if ({C4, V, S} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_priority: got C4=%b V=%b S=%b, want all 0", C4, V, S);
        end
        // Mid-stream reset discards the in-flight result.
        drive(4'hF, 4'hF, 1'b1, 1'b0);
        step();
        drive(4'h9, 4'h9, 1'b0, 1'b1);
        step();
        n_checks++;
        if ({C4, V, S} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_midstream: got %b, want 000000", {C4, V, S});
        end
`ifdef CLA_4_GROUP_PG_EN
        n_checks++;
        if ({PG, GG} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_midstream_group: got %b, want 00", {PG, GG});
        end
`endif
        drive(4'h9, 4'h9, 1'b0, 1'b0);
        step();
        n_checks++;
        if ({C4, V, S} !== ref_sum(4'h9, 4'h9, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_recover: got %b, want %b", {C4, V, S},
                     ref_sum(4'h9, 4'h9, 1'b0));
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] prev;
        prev = ref_sum(4'h9, 4'h9, 1'b0);
        for (int i = 0; i < 20; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            logic       c0;
            a  = 4'($urandom_range(15));
            b  = 4'($urandom_range(15));
            c0 = 1'($urandom_range(1));
            drive(a, b, c0, 1'b0);
            #1;
            // Outputs must hold the previous result until the next rising edge.
            n_checks++;
            if ({C4, V, S} !== prev) begin
                n_fail++;
                $display("FAIL hold_%0d: got %b, want %b", i, {C4, V, S}, prev);
            end
            step();
            prev = ref_sum(a, b, c0);
            n_checks++;
            if ({C4, V, S} !== prev) begin
                n_fail++;
                $display("FAIL b2b_%0d: a=%h b=%h c0=%b got %b, want %b", i, a, b, c0,
                         {C4, V, S}, prev);
            end
        end
    endtask

    task automatic test_exhaustive;
        int errs;
        errs = 0;
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            logic [5:0] exp;
            v   = 9'(i);
            exp = ref_sum(v[3:0], v[7:4], v[8]);
            drive(v[3:0], v[7:4], v[8], 1'b0);
            step();
            n_checks++;
            if ({C4, V, S} !== exp) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL sweep: a=%h b=%h c0=%b got %b, want %b", v[3:0], v[7:4],
                             v[8], {C4, V, S}, exp);
            end
`ifdef CLA_4_GROUP_PG_EN
            n_checks++;
            if ({PG, GG} !== ref_group(v[3:0], v[7:4])) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL sweep_group: a=%h b=%h got %b, want %b", v[3:0], v[7:4],
                             {PG, GG}, ref_group(v[3:0], v[7:4]));
            end
`endif
        end
    endtask

    task automatic test_random_reset;
        for (int i = 0; i < 200; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            logic       c0;
            logic       r;
            logic [5:0] exp;
            a   = 4'($urandom);
            b   = 4'($urandom);
            c0  = 1'($urandom);
            r   = ($urandom_range(9) == 0);
            exp = r ? 6'b0 : ref_sum(a, b, c0);
            drive(a, b, c0, r);
            step();
            n_checks++;
            if ({C4, V, S} !== exp) begin
                n_fail++;
                $display("FAIL random_%0d: a=%h b=%h c0=%b rst=%b got %b, want %b", i, a, b,
                         c0, r, {C4, V, S}, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        A   = 4'h0;
        B   = 4'h0;
        C0  = 1'b0;
        test_reset();
        test_directed();
        test_reset_priority();
        test_back_to_back();
        test_exhaustive();
        test_random_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
